calc_keypad_fsm: RTL and testbench
==================================

Name: calc_keypad_fsm

Overview:
Clocked, parametrised successor of the single-digit keypad entry ROM. It assembles multi-digit operands N1 and N2 and an operator from a 4-bit keypad code stream, and issues a one-cycle execute strobe on '='. It adds clear, backspace, overflow flagging and a result/hold state, and feeds the downstream ALU and display blocks.

Parameters:
DIGITS, 4, maximum decimal digits accepted per operand.
W, 14, operand register width; must satisfy 2^W > 10^DIGITS - 1.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
tecla  in  4  keypad code: 0-9 digit, A add, B sub, C mul, D equals, E clear, F backspace.
ready  in  1  key-valid level, synchronous to clk; a key is accepted only on its rising edge.
n1  out  W  operand 1, binary.
n2  out  W  operand 2, binary.
op  out  4  latched operator code: A, B or C; 0 = none.
cnt  out  3  digit count of the operand currently being entered; clog2(DIGITS+1) bits, 3 at default.
state  out  2  00 N1, 01 N2, 10 RES; 11 unused.
exec  out  1  one-cycle pulse when '=' is accepted.
done  out  1  high while in RES.
ovf  out  1  sticky; set when a digit is dropped because cnt == DIGITS.

Behaviour:
- Reset (synchronous): state=N1; n1, n2, op, cnt, exec, ovf = 0; ready_q = 0. Reset has priority over any key in the same cycle.
- Key event: ready=1 and ready_q=0 at a clk edge, where ready_q is ready registered on the previous edge.
  - Holding ready high produces no repeats.
  - Outputs reflect the key after that same edge (1-cycle latency).
- Digit d, state N1 or N2:
  - If cnt < DIGITS: operand = operand*10 + d, then cnt++.
  - Else: operand unchanged and ovf=1.
  - Leading zeros count as digits.
- Operator key (A, B, C):
  - N1 with cnt>0: op=key, n2=0, cnt=0, go to N2.
  - N1 with cnt=0: ignored.
  - N2 with cnt=0: op replaced by the new key.
  - N2 with cnt>0: ignored.
  - RES: ignored.
- D (equals):
  - N2 with cnt>0: exec=1 for exactly the next cycle, go to RES. n1, n2 and op hold.
  - Any other case: ignored.
- E (clear), any state: same effect as reset (ready_q still tracks ready).
- F (backspace):
  - N1 or N2 with cnt>0: operand = operand/10 (integer), cnt--. ovf unaffected.
  - N2 with cnt=0: go to N1, op=0, cnt = digit count of n1 (kept in an internal register).
  - N1 with cnt=0: ignored.
  - RES: ignored.
- RES state:
  - Digit d: n1=d, n2=0, op=0, cnt=1, ovf=0, go to N1.
  - All other keys except E are ignored.
- exec is never high for two consecutive cycles. done = (state==RES). State 11 is unreachable; if entered, the next edge forces reset values.
- Arithmetic: multiply-by-10 is computed at W+4 bits then truncated to W bits. Truncation is lossless given the W constraint.

Test Plan:
- Reset, then keys 1,2,A,3,4,D (each a rising edge on ready) -> n1=12, op=A, n2=34, exec single pulse, state=10, done=1.
- DIGITS=4: keys 9,9,9,9,9 -> n1=9999, cnt=4, ovf=1; then F -> n1=999, cnt=3, ovf still 1.
- Key 5, then B, then C with no N2 digits -> op=C, state=01; then F -> state=00, op=0, n1=5, cnt=1.
- ready held high 10 cycles with tecla=7 -> n1=7 only; no repeat accepted.
- Mid-entry (n1=42, state N2) assert reset together with a ready edge on key 3 -> all outputs 0, state=00; key discarded.
- From RES (n1=12, n2=34): key 6 -> n1=6, n2=0, op=0, state=00; key E at any point -> all zero.

Source files
------------

// File: rtl/calc_keypad_fsm.sv
// Keypad entry FSM: builds decimal operands n1/n2 and an operator from a 4-bit key stream, strobes exec on '='.
// Latency: a key accepted on a rising edge of ready is visible on all outputs right after that same clock edge.
// Backpressure: none; one key per ready rising edge, held levels never repeat, keys that do not apply are dropped.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset (wins over a key in the same cycle)
//   tecla[3:0], ready   key code (0-9 digit, A add, B sub, C mul, D equals, E clear, F backspace) and key-valid level
//   n1, n2 [W-1:0]      binary operands
//   op[3:0]             latched operator (A/B/C, 0 = none)
//   cnt[CW-1:0]         digit count of the operand being entered
//   state[1:0]          00 N1, 01 N2, 10 RES
//   exec                one-cycle strobe when '=' is accepted
//   done                high while in RES
//   ovf                 sticky flag: a digit was dropped because the operand was already full

module calc_keypad_fsm #(
    parameter int DIGITS = 4,
    parameter int W      = 14,
    localparam int CW    = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    tecla,
    input  logic          ready,
    output logic [W-1:0]  n1,
    output logic [W-1:0]  n2,
    output logic [3:0]    op,
    output logic [CW-1:0] cnt,
    output logic [1:0]    state,
    output logic          exec,
    output logic          done,
    output logic          ovf
);

    // State encoding is visible on the state port and must stay stable for downstream blocks.
    localparam logic [1:0] ST_N1  = 2'b00;
    localparam logic [1:0] ST_N2  = 2'b01;
    localparam logic [1:0] ST_RES = 2'b10;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_BS  = 4'hF;

    localparam logic [CW-1:0]  CNT_MAX = CW'(DIGITS);
    localparam logic [W+3:0]   TEN_X   = (W+4)'(10);
    localparam logic [W-1:0]   TEN     = W'(10);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          ready_q;
    logic [CW-1:0] n1_cnt;     // digit count of n1, restored when backspacing out of N2

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic key_evt;
    logic is_digit;
    logic is_oper;
    logic is_eq;
    logic is_clr;
    logic is_bs;

    always_comb begin
        key_evt  = ready & ~ready_q;
        is_digit = (tecla <= 4'd9);
        is_oper  = (tecla == KEY_ADD) || (tecla == KEY_SUB) || (tecla == KEY_MUL);
        is_eq    = (tecla == KEY_EQ);
        is_clr   = (tecla == KEY_CLR);
        is_bs    = (tecla == KEY_BS);
    end

    // ------------------------------------------------------------------
    // Operand datapath: shared by N1 and N2, selects the active operand.
    // ------------------------------------------------------------------
    logic          in_n2;
    logic [W-1:0]  cur_opnd;
    logic [W-1:0]  opnd_mul;   // cur_opnd*10 + digit
    logic [W-1:0]  opnd_div;   // cur_opnd/10
    logic [W-1:0]  digit_w;
    logic          cnt_full;
    logic          cnt_zero;

    always_comb begin
        in_n2    = (state == ST_N2);
        cur_opnd = in_n2 ? n2 : n1;
        digit_w  = {{(W-4){1'b0}}, tecla};
        // Product is formed 4 bits wider than the operand; the upper bits are
        // always zero because an operand never exceeds DIGITS decimal digits.
        opnd_mul = W'({4'b0000, cur_opnd} * TEN_X + {{W{1'b0}}, tecla});
        opnd_div = cur_opnd / TEN;
        cnt_full = (cnt >= CNT_MAX);
        cnt_zero = (cnt == '0);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [1:0]    state_n;
    logic [W-1:0]  n1_n;
    logic [W-1:0]  n2_n;
    logic [3:0]    op_n;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] n1_cnt_n;
    logic          exec_n;
    logic          ovf_n;
    logic          clear_all;

    always_comb begin
        state_n   = state;
        n1_n      = n1;
        n2_n      = n2;
        op_n      = op;
        cnt_n     = cnt;
        n1_cnt_n  = n1_cnt;
        exec_n    = 1'b0;      // exec only ever lasts one cycle
        ovf_n     = ovf;
        clear_all = 1'b0;

        if (state == 2'b11) begin
            // Illegal encoding: recover to the reset values.
            clear_all = 1'b1;
        end else if (key_evt) begin
            if (is_clr) begin
                clear_all = 1'b1;
            end else if (state == ST_RES) begin
                // A digit after a result starts a fresh calculation.
                if (is_digit) begin
                    n1_n     = digit_w;
                    n2_n     = '0;
                    op_n     = 4'h0;
                    cnt_n    = CW'(1);
                    n1_cnt_n = '0;
                    ovf_n    = 1'b0;
                    state_n  = ST_N1;
                end
            end else begin
                // N1 or N2
                if (is_digit) begin
                    if (!cnt_full) begin
                        if (in_n2) n2_n = opnd_mul;
                        else       n1_n = opnd_mul;
                        cnt_n = cnt + CW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else if (is_oper) begin
                    if (!in_n2 && !cnt_zero) begin
                        op_n     = tecla;
                        n2_n     = '0;
                        n1_cnt_n = cnt;
                        cnt_n    = '0;
                        state_n  = ST_N2;
                    end else if (in_n2 && cnt_zero) begin
                        // Operator change before any n2 digit.
                        op_n = tecla;
                    end
                end else if (is_eq) begin
                    if (in_n2 && !cnt_zero) begin
                        exec_n  = 1'b1;
                        state_n = ST_RES;
                    end
                end else if (is_bs) begin
                    if (!cnt_zero) begin
                        if (in_n2) n2_n = opnd_div;
                        else       n1_n = opnd_div;
                        cnt_n = cnt - CW'(1);
                    end else if (in_n2) begin
                        // Backspace past the empty n2 reopens n1 for editing.
                        op_n    = 4'h0;
                        cnt_n   = n1_cnt;
                        state_n = ST_N1;
                    end
                end
            end
        end

        if (clear_all) begin
            state_n  = ST_N1;
            n1_n     = '0;
            n2_n     = '0;
            op_n     = 4'h0;
            cnt_n    = '0;
            n1_cnt_n = '0;
            exec_n   = 1'b0;
            ovf_n    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_N1;
            n1      <= '0;
            n2      <= '0;
            op      <= 4'h0;
            cnt     <= '0;
            n1_cnt  <= '0;
            exec    <= 1'b0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            n1      <= n1_n;
            n2      <= n2_n;
            op      <= op_n;
            cnt     <= cnt_n;
            n1_cnt  <= n1_cnt_n;
            exec    <= exec_n;
            ovf     <= ovf_n;
            // Clear still tracks ready so a held key is not re-accepted.
            ready_q <= ready;
        end
    end

    assign done = (state == ST_RES);

endmodule

// File: tb/tb_calc_keypad_fsm.sv
// Testbench for calc_keypad_fsm: table vectors, directed corner sequences, randomized keys vs a reference model.
// Latency: outputs are checked 1 time unit after every rising clock edge.
// Backpressure: not applicable; the bench drives ready levels directly.

module tb_calc_keypad_fsm;

    localparam int DIGITS = 4;
    localparam int W      = 14;
    localparam int CW     = $clog2(DIGITS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    tecla = 4'h0;
    logic          ready = 1'b0;
    logic [W-1:0]  n1;
    logic [W-1:0]  n2;
    logic [3:0]    op;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic          exec;
    logic          done;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;

    calc_keypad_fsm #(.DIGITS(DIGITS), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .tecla (tecla),
        .ready (ready),
        .n1    (n1),
        .n2    (n2),
        .op    (op),
        .cnt   (cnt),
        .state (state),
        .exec  (exec),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: operands as plain integers indexed by entry phase
    // (0 = first operand, 1 = second), phase 2 = result shown.
    // ------------------------------------------------------------------
    int m_val[2];
    int m_dig[2];
    int m_op    = 0;
    int m_phase = 0;
    int m_exec  = 0;
    int m_ovf   = 0;
    int m_rq    = 0;

    function automatic void m_clear();
        m_val[0] = 0; m_val[1] = 0;
        m_dig[0] = 0; m_dig[1] = 0;
        m_op = 0; m_phase = 0; m_exec = 0; m_ovf = 0;
    endfunction

    function automatic void m_key(int k);
        int e;
        e = (m_phase == 1) ? 1 : 0;
        if (k == 14) begin
            m_clear();
        end else if (m_phase == 2) begin
            if (k <= 9) begin
                m_val[0] = k; m_dig[0] = 1;
                m_val[1] = 0; m_dig[1] = 0;
                m_op = 0; m_ovf = 0; m_phase = 0;
            end
        end else if (k <= 9) begin
            if (m_dig[e] < DIGITS) begin
                m_val[e] = m_val[e] * 10 + k;
                m_dig[e] = m_dig[e] + 1;
            end else begin
                m_ovf = 1;
            end
        end else if (k >= 10 && k <= 12) begin
            if (m_phase == 0 && m_dig[0] > 0) begin
                m_op = k; m_val[1] = 0; m_dig[1] = 0; m_phase = 1;
            end else if (m_phase == 1 && m_dig[1] == 0) begin
                m_op = k;
            end
        end else if (k == 13) begin
            if (m_phase == 1 && m_dig[1] > 0) begin
                m_exec = 1; m_phase = 2;
            end
        end else if (k == 15) begin
            if (m_dig[e] > 0) begin
                m_val[e] = m_val[e] / 10;
                m_dig[e] = m_dig[e] - 1;
            end else if (m_phase == 1) begin
                m_phase = 0; m_op = 0;
            end
        end
    endfunction

    function automatic void m_step(logic r, logic rd, logic [3:0] k);
        if (r) begin
            m_clear();
            m_rq = 0;
        end else begin
            m_exec = 0;
            if (rd && m_rq == 0) m_key(int'(k));
            m_rq = rd ? 1 : 0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int mcnt;
        mcnt = (m_phase == 0) ? m_dig[0] : m_dig[1];
        check("mdl_n1",    32'(n1),    32'(m_val[0]));
        check("mdl_n2",    32'(n2),    32'(m_val[1]));
        check("mdl_op",    32'(op),    32'(m_op));
        check("mdl_cnt",   32'(cnt),   32'(mcnt));
        check("mdl_state", 32'(state), 32'(m_phase));
        check("mdl_exec",  32'(exec),  32'(m_exec));
        check("mdl_done",  32'(done),  32'(m_phase == 2));
        check("mdl_ovf",   32'(ovf),   32'(m_ovf));
    endtask

    task automatic cycle(input logic r, input logic rd, input logic [3:0] k);
        reset = r; ready = rd; tecla = k;
        @(posedge clk);
        m_step(r, rd, k);
        #1;
        check_model();
    endtask

    task automatic press(input logic [3:0] k);
        cycle(1'b0, 1'b1, k);
        cycle(1'b0, 1'b0, k);
    endtask

    // ------------------------------------------------------------------
    // Vector table: {reset, ready, key} -> expected outputs after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       rdy;
        logic [3:0] key;
        int         e_n1;
        int         e_n2;
        int         e_op;
        int         e_cnt;
        int         e_st;
        int         e_exec;
        int         e_ovf;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //            rst   rdy   key    n1  n2  op  cnt st ex ovf
        tbl[0]  = '{1'b1, 1'b0, 4'h0,  0,  0,  0,  0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 4'h1,  1,  0,  0,  1, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 4'h1,  1,  0,  0,  1, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 4'h2, 12,  0,  0,  2, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 4'h2, 12,  0,  0,  2, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 4'hA, 12,  0, 10,  0, 1, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 4'hA, 12,  0, 10,  0, 1, 0, 0};
        tbl[7]  = '{1'b0, 1'b1, 4'h3, 12,  3, 10,  1, 1, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 4'h3, 12,  3, 10,  1, 1, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 4'h4, 12, 34, 10,  2, 1, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 4'h4, 12, 34, 10,  2, 1, 0, 0};
        tbl[11] = '{1'b0, 1'b1, 4'hD, 12, 34, 10,  2, 2, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 4'hD, 12, 34, 10,  2, 2, 0, 0};
        tbl[13] = '{1'b0, 1'b1, 4'h6,  6,  0,  0,  1, 0, 0, 0};
        tbl[14] = '{1'b0, 1'b0, 4'h6,  6,  0,  0,  1, 0, 0, 0};
        tbl[15] = '{1'b0, 1'b1, 4'hE,  0,  0,  0,  0, 0, 0, 0};
        tbl[16] = '{1'b0, 1'b0, 4'hE,  0,  0,  0,  0, 0, 0, 0};

        m_clear();

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rst, tbl[i].rdy, tbl[i].key);
            check("tbl_n1",    32'(n1),    32'(tbl[i].e_n1));
            check("tbl_n2",    32'(n2),    32'(tbl[i].e_n2));
            check("tbl_op",    32'(op),    32'(tbl[i].e_op));
            check("tbl_cnt",   32'(cnt),   32'(tbl[i].e_cnt));
            check("tbl_state", 32'(state), 32'(tbl[i].e_st));
            check("tbl_exec",  32'(exec),  32'(tbl[i].e_exec));
            check("tbl_done",  32'(done),  32'(tbl[i].e_st == 2));
            check("tbl_ovf",   32'(ovf),   32'(tbl[i].e_ovf));
        end

        // Overflow at DIGITS, then backspace keeps the sticky flag.
        for (int i = 0; i < 5; i++) press(4'h9);
        check("ovf_n1",  32'(n1),  32'd9999);
        check("ovf_cnt", 32'(cnt), 32'd4);
        check("ovf_flag", 32'(ovf), 32'd1);
        press(4'hF);
        check("bs_n1",  32'(n1),  32'd999);
        check("bs_cnt", 32'(cnt), 32'd3);
        check("bs_ovf", 32'(ovf), 32'd1);
        press(4'hE);

        // Operator replacement and backspace from empty n2 back to n1.
        press(4'h5);
        press(4'hB);
        press(4'hC);
        check("oprep_op", 32'(op),    32'hC);
        check("oprep_st", 32'(state), 32'd1);
        press(4'hF);
        check("bsn2_st",  32'(state), 32'd0);
        check("bsn2_op",  32'(op),    32'd0);
        check("bsn2_n1",  32'(n1),    32'd5);
        check("bsn2_cnt", 32'(cnt),   32'd1);
        press(4'hE);

        // Held ready gives a single key.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'h7);
        check("hold_n1",  32'(n1),  32'd7);
        check("hold_cnt", 32'(cnt), 32'd1);
        cycle(1'b0, 1'b0, 4'h7);
        press(4'hE);

        // Reset coinciding with a key edge discards the key.
        press(4'h4);
        press(4'h2);
        press(4'hA);
        check("mid_n1", 32'(n1),    32'd42);
        check("mid_st", 32'(state), 32'd1);
        cycle(1'b1, 1'b1, 4'h3);
        check("rstkey_n1",  32'(n1),    32'd0);
        check("rstkey_n2",  32'(n2),    32'd0);
        check("rstkey_op",  32'(op),    32'd0);
        check("rstkey_st",  32'(state), 32'd0);
        check("rstkey_cnt", 32'(cnt),   32'd0);
        cycle(1'b0, 1'b0, 4'h0);

        // Randomized keys, ready levels and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic       r;
            logic       rd;
            logic [3:0] k;
            r  = ($urandom_range(0, 99) == 0);
            rd = 1'($urandom_range(0, 1));
            // Bias toward digits so operands fill and overflow.
            if ($urandom_range(0, 2) == 0) k = 4'($urandom_range(10, 15));
            else                           k = 4'($urandom_range(0, 9));
            cycle(r, rd, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
